// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer frame transmit path.
package accel_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned AXIS_W      = 2;
  localparam int unsigned GAP_W       = 8;
  localparam int unsigned FRAME_WORDS = 4;
  localparam int unsigned FRAME_BYTES = 8;

  localparam logic [AXIS_W-1:0] AXIS_X    = 2'd0;
  localparam logic [AXIS_W-1:0] AXIS_Y    = 2'd1;
  localparam logic [AXIS_W-1:0] AXIS_Z    = 2'd2;
  localparam logic [AXIS_W-1:0] AXIS_SYNC = 2'd3;

  localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_A,
    ST_WAIT_A,
    ST_SEND_B,
    ST_WAIT_B,
    ST_GAP
  } state_e;

  // First or second byte of a word on the wire, depending on byte order.
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w,
                                                  input logic msb_first,
                                                  input logic second);
    return (msb_first ^ second) ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/accel_frame_tx_sequencer.sv
// Pulls one word per axis FIFO, appends a sync word, and streams the frame
// byte by byte through a start/done UART handshake.
module accel_frame_tx_sequencer
  import accel_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter bit                MSB_FIRST = 1'b1,
  parameter int unsigned       FRAME_GAP = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [WORD_W-1:0]   x_data,
  input  logic [WORD_W-1:0]   y_data,
  input  logic [WORD_W-1:0]   z_data,
  input  logic                x_empty,
  input  logic                y_empty,
  input  logic                z_empty,
  output logic                x_pop,
  output logic                y_pop,
  output logic                z_pop,
  output logic [BYTE_W-1:0]   tx_byte,
  output logic                tx_start,
  input  logic                tx_busy,
  input  logic                tx_done,
  output logic [AXIS_W-1:0]   axis_sel,
  output logic                word_complete,
  output logic                frame_active,
  output logic [15:0]         frames_sent
);

  localparam logic [AXIS_W-1:0] LAST_AXIS = AXIS_W'(FRAME_WORDS - 1);

  state_e              state_q, state_d;
  logic [AXIS_W-1:0]   axis_q, axis_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                x_pop_q, x_pop_d, y_pop_q, y_pop_d, z_pop_q, z_pop_d;
  logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
  logic                tx_start_q, tx_start_d;
  logic                word_complete_q, word_complete_d;
  logic                frame_active_q, frame_active_d;
  logic [15:0]         frames_sent_q, frames_sent_d;

  // Next-state and registered-output logic; pops are issued on entry to LOAD.
  always_comb begin
    state_d         = state_q;
    axis_d          = axis_q;
    word_d          = word_q;
    gap_d           = gap_q;
    x_pop_d         = 1'b0;
    y_pop_d         = 1'b0;
    z_pop_d         = 1'b0;
    tx_byte_d       = tx_byte_q;
    tx_start_d      = 1'b0;
    word_complete_d = 1'b0;
    frame_active_d  = frame_active_q;
    frames_sent_d   = frames_sent_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && !x_empty && !y_empty && !z_empty) begin
          axis_d         = AXIS_X;
          x_pop_d        = 1'b1;
          frame_active_d = 1'b1;
          state_d        = ST_LOAD;
        end
      end
      ST_LOAD: begin
        unique case (axis_q)
          AXIS_X:  word_d = x_data;
          AXIS_Y:  word_d = y_data;
          AXIS_Z:  word_d = z_data;
          default: word_d = SYNC_WORD;
        endcase
        state_d = ST_SEND_A;
      end
      ST_SEND_A: begin
        if (!tx_busy) begin
          tx_byte_d  = pick_byte(word_q, MSB_FIRST, 1'b0);
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_A;
        end
      end
      ST_WAIT_A: begin
        if (tx_done) state_d = ST_SEND_B;
      end
      ST_SEND_B: begin
        if (!tx_busy) begin
          tx_byte_d  = pick_byte(word_q, MSB_FIRST, 1'b1);
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (tx_done) begin
          word_complete_d = 1'b1;
          if (axis_q != LAST_AXIS) begin
            axis_d  = axis_q + AXIS_W'(1);
            state_d = ST_LOAD;
            unique case (axis_q)
              AXIS_X:  y_pop_d = 1'b1;
              AXIS_Y:  z_pop_d = 1'b1;
              default: ;
            endcase
          end else begin
            frames_sent_d  = frames_sent_q + 16'd1;
            frame_active_d = 1'b0;
            gap_d          = GAP_W'(FRAME_GAP);
            state_d        = (FRAME_GAP == 0) ? ST_IDLE : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      axis_q          <= AXIS_X;
      word_q          <= '0;
      gap_q           <= '0;
      x_pop_q         <= 1'b0;
      y_pop_q         <= 1'b0;
      z_pop_q         <= 1'b0;
      tx_byte_q       <= '0;
      tx_start_q      <= 1'b0;
      word_complete_q <= 1'b0;
      frame_active_q  <= 1'b0;
      frames_sent_q   <= '0;
    end else begin
      state_q         <= state_d;
      axis_q          <= axis_d;
      word_q          <= word_d;
      gap_q           <= gap_d;
      x_pop_q         <= x_pop_d;
      y_pop_q         <= y_pop_d;
      z_pop_q         <= z_pop_d;
      tx_byte_q       <= tx_byte_d;
      tx_start_q      <= tx_start_d;
      word_complete_q <= word_complete_d;
      frame_active_q  <= frame_active_d;
      frames_sent_q   <= frames_sent_d;
    end
  end

  assign x_pop         = x_pop_q;
  assign y_pop         = y_pop_q;
  assign z_pop         = z_pop_q;
  assign tx_byte       = tx_byte_q;
  assign tx_start      = tx_start_q;
  assign axis_sel      = axis_q;
  assign word_complete = word_complete_q;
  assign frame_active  = frame_active_q;
  assign frames_sent   = frames_sent_q;

endmodule

// File: tb/tb_accel_frame_tx_sequencer.sv
// Directed bench for accel_frame_tx_sequencer: byte scoreboard plus a simple
// UART model that holds busy for a fixed number of cycles per byte.
module tb_accel_frame_tx_sequencer;
  import accel_pkg::*;

  localparam int unsigned BUSY_LEN = 10;
  localparam int unsigned TMO      = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] x_data = '0, y_data = '0, z_data = '0;
  logic        x_empty = 1'b1, y_empty = 1'b1, z_empty = 1'b1;
  logic        x_pop, y_pop, z_pop;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic [1:0]  axis_sel;
  logic        word_complete;
  logic        frame_active;
  logic [15:0] frames_sent;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int uart_cnt = 0;
  bit force_busy = 1'b0;
  int n_x, n_y, n_z, n_wc, n_sent, n_multi, n_chg;
  logic [7:0] exp_q[$];

  accel_frame_tx_sequencer #(
    .SYNC_WORD(16'hFFFF),
    .MSB_FIRST(1'b1),
    .FRAME_GAP(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .x_empty(x_empty), .y_empty(y_empty), .z_empty(z_empty),
    .x_pop(x_pop), .y_pop(y_pop), .z_pop(z_pop),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .axis_sel(axis_sel), .word_complete(word_complete),
    .frame_active(frame_active), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic push_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    x_data = x;
    y_data = y;
    z_data = z;
    push_word(x);
    push_word(y);
    push_word(z);
    push_word(16'hFFFF);
  endtask

  task automatic clear_counts();
    n_x = 0; n_y = 0; n_z = 0; n_wc = 0; n_sent = 0; n_chg = 0;
  endtask

  // One clock: sample outputs just after the edge, score bytes, run the UART.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (x_pop) n_x++;
    if (y_pop) n_y++;
    if (z_pop) n_z++;
    if (32'(x_pop) + 32'(y_pop) + 32'(z_pop) > 32'd1) n_multi++;
    if (word_complete) n_wc++;
    tx_done = 1'b0;
    if (tx_start) begin
      n_sent++;
      chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("byte_order", 32'(tx_byte), 32'(e));
      end
      uart_cnt = BUSY_LEN;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) tx_done = 1'b1;
    end
    tx_busy = force_busy || (uart_cnt > 0);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!frame_active && n < TMO) begin
      tick();
      n++;
    end
    chk({tag, "_start_timeout"}, 32'(n < TMO), 32'd1);
  endtask

  task automatic wait_frame_end(input string tag);
    int n = 0;
    while (frame_active && n < TMO) begin
      tick();
      n++;
    end
    chk({tag, "_end_timeout"}, 32'(n < TMO), 32'd1);
  endtask

  initial begin
    int n;
    int end_cyc;
    logic [7:0] held;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {x_pop, y_pop, z_pop, tx_start, word_complete, frame_active,
                        axis_sel, tx_byte, frames_sent}, 32'd0);
    rst_n = 1'b1;

    // Start gated while Z is empty, then single frame
    clear_counts();
    push_frame(16'h1234, 16'hABCD, 16'h0F0F);
    enable  = 1'b1;
    x_empty = 1'b0;
    y_empty = 1'b0;
    z_empty = 1'b1;
    repeat (10) tick();
    chk("gate_no_start", 32'(n_sent), 32'd0);
    chk("gate_no_pop", 32'(n_x + n_y + n_z), 32'd0);
    chk("gate_idle", 32'(frame_active), 32'd0);
    z_empty = 1'b0;
    // z_empty drops now, is sampled at the next edge; tx_start lands 2 edges after that
    n = 0;
    while (n < TMO) begin
      tick();
      n++;
      if (tx_start) break;
    end
    chk("start_latency", 32'(n), 32'd3);
    enable = 1'b0;
    wait_frame_end("f1");
    chk("f1_bytes", 32'(n_sent), 32'd8);
    chk("f1_pops", {8'd0, 8'(n_x), 8'(n_y), 8'(n_z)}, 32'h00010101);
    chk("f1_word_complete", 32'(n_wc), 32'd4);
    chk("f1_frames_sent", 32'(frames_sent), 32'd1);
    chk("f1_queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (30) tick();
    chk("f1_no_second_frame", 32'(n_sent), 32'd8);

    // Enable dropped after the Y word's first byte
    clear_counts();
    push_frame(16'h0102, 16'h0304, 16'h0506);
    enable = 1'b1;
    n = 0;
    while (n_sent < 3 && n < TMO) begin
      tick();
      n++;
    end
    enable = 1'b0;
    wait_frame_end("f2");
    repeat (30) tick();
    chk("f2_bytes", 32'(n_sent), 32'd8);
    chk("f2_frames_sent", 32'(frames_sent), 32'd2);
    chk("f2_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("f2_idle", 32'(frame_active), 32'd0);

    // Backpressure in SEND_A and a spurious tx_done during LOAD
    clear_counts();
    push_frame(16'hA5C3, 16'h5A3C, 16'h7E81);
    force_busy = 1'b1;
    tx_busy    = 1'b1;
    enable     = 1'b1;
    wait_start("f3");
    tx_done = 1'b1;
    enable  = 1'b0;
    held    = tx_byte;
    repeat (50) begin
      tick();
      if (tx_byte !== held) n_chg++;
    end
    chk("bp_no_start", 32'(n_sent), 32'd0);
    chk("bp_byte_stable", 32'(n_chg), 32'd0);
    force_busy = 1'b0;
    wait_frame_end("f3");
    chk("f3_bytes", 32'(n_sent), 32'd8);
    chk("f3_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("f3_frames_sent", 32'(frames_sent), 32'd3);

    // Asynchronous reset during WAIT_B of the Z word
    clear_counts();
    x_data = 16'h1111;
    y_data = 16'h2222;
    z_data = 16'h3333;
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    enable = 1'b1;
    n = 0;
    while (n_sent < 6 && n < TMO) begin
      tick();
      n++;
    end
    enable = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {x_pop, y_pop, z_pop, tx_start, word_complete, frame_active,
                              axis_sel, tx_byte, frames_sent}, 32'd0);
    chk("async_rst_bytes_sent", 32'(n_sent), 32'd6);
    uart_cnt = 0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    clear_counts();
    push_frame(16'h4444, 16'h5555, 16'h6666);
    enable = 1'b1;
    wait_start("f4");
    chk("restart_axis_x", 32'(axis_sel), 32'(AXIS_X));
    chk("restart_pop_x", 32'(x_pop), 32'd1);
    enable = 1'b0;
    wait_frame_end("f4");
    chk("f4_bytes", 32'(n_sent), 32'd8);
    chk("f4_frames_sent", 32'(frames_sent), 32'd1);
    chk("f4_queue_drained", 32'(exp_q.size()), 32'd0);

    // Counter wrap and inter-frame gap
    force dut.frames_sent_q = 16'hFFFF;
    #1;
    release dut.frames_sent_q;
    #1;
    chk("preload_ffff", 32'(frames_sent), 32'h0000FFFF);
    clear_counts();
    push_frame(16'hBEEF, 16'hCAFE, 16'h0000);
    enable = 1'b1;
    wait_start("f5");
    wait_frame_end("f5");
    end_cyc = cyc;
    chk("wrap_to_zero", 32'(frames_sent), 32'd0);
    push_frame(16'hBEEF, 16'hCAFE, 16'h0000);
    n = 0;
    while (n < TMO) begin
      tick();
      n++;
      if (tx_start) break;
    end
    chk("gap_window", 32'((cyc - end_cyc) >= 7 && (cyc - end_cyc) <= 8), 32'd1);
    enable = 1'b0;
    wait_frame_end("f6");
    chk("f6_frames_sent", 32'(frames_sent), 32'd1);
    chk("f6_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("single_pop_per_cycle", 32'(n_multi), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
